// File: rtl/tmds_encoder_pipe.sv
// Multi-channel two-stage TMDS 8b/10b encoder.
// Stage 1 registers the transition-minimised word q_m (plus ve/control);
// stage 2 registers the DC-balanced 10-bit symbol and running disparity.
module tmds_encoder_pipe #(
  parameter int NUM_CH = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [8*NUM_CH-1:0]   data_in,
  input  logic [2*NUM_CH-1:0]   control_in,
  input  logic                  ve_in,
  output logic [10*NUM_CH-1:0]  tmds_out,
  output logic [5*NUM_CH-1:0]   tally_out
);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  logic ve_reg;

  // Video-enable delay into stage 2, shared by every channel.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ve_reg <= 1'b0;
    end else begin
      ve_reg <= ve_in;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [7:0] din;
      logic [1:0] ctrl_reg;
      logic [8:0] q_m_next;
      logic [8:0] q_m_reg;
      logic [3:0] n1_din;
      logic [3:0] n1_qm;
      logic       use_xnor;
      // bal holds N1-N0 of q_m[7:0] as a 5-bit two's complement value.
      logic [4:0] bal;
      logic [4:0] tally_reg;
      logic [4:0] tally_next;
      logic [9:0] sym_reg;
      logic [9:0] sym_next;
      logic       t_zero;
      logic       t_pos;
      logic       t_neg;

      assign din = data_in[8*gi +: 8];

      // Stage 1: choose XOR or XNOR chaining to minimise transitions.
      always_comb begin
        n1_din      = popcount8(din);
        use_xnor    = (n1_din > 4'd4) || ((n1_din == 4'd4) && !din[0]);
        q_m_next    = 9'd0;
        q_m_next[0] = din[0];
        for (int i = 1; i < 8; i++) begin
          q_m_next[i] = use_xnor ? ~(q_m_next[i-1] ^ din[i])
                                 :  (q_m_next[i-1] ^ din[i]);
        end
        q_m_next[8] = ~use_xnor;
      end

      // Stage 1 registers: q_m and the control pair travelling alongside it.
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          q_m_reg  <= 9'd0;
          ctrl_reg <= 2'd0;
        end else begin
          q_m_reg  <= q_m_next;
          ctrl_reg <= control_in[2*gi +: 2];
        end
      end

      // Stage 2: control tokens during blanking, DC balancing during video.
      always_comb begin
        n1_qm      = popcount8(q_m_reg[7:0]);
        bal        = {n1_qm, 1'b0} - 5'd8;
        t_zero     = (tally_reg == 5'd0);
        t_neg      = tally_reg[4];
        t_pos      = !t_neg && !t_zero;
        sym_next   = 10'd0;
        tally_next = tally_reg;
        if (!ve_reg) begin
          tally_next = 5'd0;
          case (ctrl_reg)
            2'b00:   sym_next = 10'b1101010100;
            2'b01:   sym_next = 10'b0010101011;
            2'b10:   sym_next = 10'b0101010100;
            default: sym_next = 10'b1010101011;
          endcase
        end else if (t_zero || (n1_qm == 4'd4)) begin
          sym_next   = {~q_m_reg[8], q_m_reg[8],
                        q_m_reg[8] ? q_m_reg[7:0] : ~q_m_reg[7:0]};
          tally_next = q_m_reg[8] ? (tally_reg + bal) : (tally_reg - bal);
        end else if ((t_pos && (n1_qm > 4'd4)) || (t_neg && (n1_qm < 4'd4))) begin
          sym_next   = {1'b1, q_m_reg[8], ~q_m_reg[7:0]};
          tally_next = tally_reg + {3'd0, q_m_reg[8], 1'b0} - bal;
        end else begin
          sym_next   = {1'b0, q_m_reg[8], q_m_reg[7:0]};
          tally_next = tally_reg + bal - (q_m_reg[8] ? 5'd0 : 5'd2);
        end
      end

      // Stage 2 registers: symbol and disparity update on the same edge.
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          sym_reg   <= 10'd0;
          tally_reg <= 5'd0;
        end else begin
          sym_reg   <= sym_next;
          tally_reg <= tally_next;
        end
      end

      assign tmds_out[10*gi +: 10] = sym_reg;
      assign tally_out[5*gi +: 5]  = tally_reg;
    end
  endgenerate

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// Scoreboard bench for tmds_encoder_pipe: directed vectors with hand-computed
// symbols, mid-stream reset, then a random soak against a behavioural model.
module tb_tmds_encoder_pipe;
  localparam int NUM_CH = 3;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic [8*NUM_CH-1:0]  data_in;
  logic [2*NUM_CH-1:0]  control_in;
  logic                 ve_in;
  logic [10*NUM_CH-1:0] tmds_out;
  logic [5*NUM_CH-1:0]  tally_out;

  tmds_encoder_pipe #(.NUM_CH(NUM_CH)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .data_in    (data_in),
    .control_in (control_in),
    .ve_in      (ve_in),
    .tmds_out   (tmds_out),
    .tally_out  (tally_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          due;
    logic [29:0] sym;
    logic [14:0] tally;
    logic        ve;
    logic [23:0] data;
    string       name;
    bit          verbose;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   mt[NUM_CH];

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [7:0] dec(input logic [9:0] s);
    logic [7:0] b;
    logic [7:0] o;
    b    = s[9] ? ~s[7:0] : s[7:0];
    o[0] = b[0];
    for (int i = 1; i < 8; i++) begin
      o[i] = s[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
    end
    return o;
  endfunction

  // Behavioural encoder, integer disparity.
  task automatic ref_enc(input logic [7:0] d, input logic ve, input logic [1:0] c,
                         input int t_in, output logic [9:0] s, output int t_out);
    int n1, cnt1, cnt0;
    logic [8:0] q;
    t_out = t_in;
    if (!ve) begin
      t_out = 0;
      case (c)
        2'b00:   s = 10'b1101010100;
        2'b01:   s = 10'b0010101011;
        2'b10:   s = 10'b0101010100;
        default: s = 10'b1010101011;
      endcase
    end else begin
      n1   = $countones(d);
      q    = 9'd0;
      q[0] = d[0];
      if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
        for (int i = 1; i < 8; i++) q[i] = ~(q[i-1] ^ d[i]);
        q[8] = 1'b0;
      end else begin
        for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
        q[8] = 1'b1;
      end
      cnt1 = $countones(q[7:0]);
      cnt0 = 8 - cnt1;
      if (t_in == 0 || cnt1 == cnt0) begin
        s     = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
        t_out = t_in + (q[8] ? (cnt1 - cnt0) : (cnt0 - cnt1));
      end else if ((t_in > 0 && cnt1 > cnt0) || (t_in < 0 && cnt0 > cnt1)) begin
        s     = {1'b1, q[8], ~q[7:0]};
        t_out = t_in + (q[8] ? 2 : 0) + (cnt0 - cnt1);
      end else begin
        s     = {1'b0, q[8], q[7:0]};
        t_out = t_in + (q[8] ? 0 : -2) + (cnt1 - cnt0);
      end
    end
  endtask

  task automatic push_exp(input int due, input logic [29:0] es, input logic [14:0] et,
                          input logic ve, input logic [23:0] d, input string name,
                          input bit verbose);
    exp_t e;
    e.due = due; e.sym = es; e.tally = et; e.ve = ve; e.data = d;
    e.name = name; e.verbose = verbose;
    sb.push_back(e);
  endtask

  task automatic drive(input logic ve, input logic [23:0] d, input logic [5:0] c,
                       input logic [29:0] es, input logic [14:0] et,
                       input string name, input bit verbose);
    rst_in = 1'b0; ve_in = ve; data_in = d; control_in = c;
    push_exp(cyc + 2, es, et, ve, d, name, verbose);
    @(posedge clk_in); #1;
  endtask

  // One reset cycle with live-looking inputs that must be discarded.
  task automatic reset_cycle(input string name);
    rst_in = 1'b1; ve_in = 1'b1; data_in = 24'($urandom); control_in = 6'($urandom);
    while (sb.size() > 0 && sb[$].due >= cyc + 1) void'(sb.pop_back());
    push_exp(cyc + 1, 30'd0, 15'd0, 1'b0, 24'd0, name, 1'b1);
    for (int c = 0; c < NUM_CH; c++) mt[c] = 0;
    @(posedge clk_in); #1;
  endtask

  task automatic soak(input int n);
    logic [23:0] d;
    logic [5:0]  ctl;
    logic        ve;
    logic [29:0] es;
    logic [14:0] et;
    logic [9:0]  s;
    int          tn;
    for (int i = 0; i < n; i++) begin
      if (i == n / 2) reset_cycle("soak_rst");
      d   = 24'($urandom);
      ctl = 6'($urandom);
      ve  = ($urandom_range(0, 4) != 0);
      for (int c = 0; c < NUM_CH; c++) begin
        ref_enc(d[8*c +: 8], ve, ctl[2*c +: 2], mt[c], s, tn);
        es[10*c +: 10] = s;
        et[5*c +: 5]   = 5'(tn);
        mt[c]          = tn;
      end
      drive(ve, d, ctl, es, et, "soak", 1'b0);
    end
  endtask

  // Monitor: bound-check disparity every cycle, pop and compare due entries.
  always @(negedge clk_in) begin
    exp_t e;
    int   bad;
    logic signed [4:0] tv;
    if (cyc > 0) begin
      bad = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        tv = $signed(tally_out[5*c +: 5]);
        if (tv > 5'sd10 || tv < -5'sd10) bad = 1;
      end
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("[TB] FAIL tally_bound cyc=%0d tally=%b required each in [-10,10]",
                 cyc, tally_out);
      end
    end
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      n_tests++;
      if (e.due < cyc) begin
        n_fail++;
        $display("[TB] FAIL %s missed slot due=%0d now=%0d", e.name, e.due, cyc);
      end else begin
        if (tmds_out !== e.sym) begin
          n_fail++;
          $display("[TB] FAIL %s_sym cyc=%0d got=%b required=%b", e.name, cyc, tmds_out, e.sym);
        end
        n_tests++;
        if (tally_out !== e.tally) begin
          n_fail++;
          $display("[TB] FAIL %s_tally cyc=%0d got=%b required=%b", e.name, cyc, tally_out, e.tally);
        end
        if (e.ve) begin
          for (int c = 0; c < NUM_CH; c++) begin
            n_tests++;
            if (dec(tmds_out[10*c +: 10]) !== e.data[8*c +: 8]) begin
              n_fail++;
              $display("[TB] FAIL %s_decode ch%0d cyc=%0d got=%h required=%h", e.name, c,
                       cyc, dec(tmds_out[10*c +: 10]), e.data[8*c +: 8]);
            end
          end
        end
        if (e.verbose)
          $display("[TB] %s cyc=%0d tmds=%b tally=%b", e.name, cyc, tmds_out, tally_out);
      end
    end
  end

  localparam logic [9:0] TK0 = 10'b1101010100;
  localparam logic [9:0] TK1 = 10'b0010101011;
  localparam logic [9:0] TK2 = 10'b0101010100;
  localparam logic [9:0] TK3 = 10'b1010101011;
  localparam logic [9:0] S00 = 10'b0100000000;

  initial begin
    for (int c = 0; c < NUM_CH; c++) mt[c] = 0;
    rst_in = 1'b1; ve_in = 1'b0; data_in = '0; control_in = '0;

    reset_cycle("reset0");
    reset_cycle("reset1");

    // Control tokens, channels rotated {ch2,ch1,ch0}.
    drive(1'b0, 24'h0, 6'b11_01_00, {TK3, TK1, TK0}, 15'd0, "ctrl_a", 1'b1);
    drive(1'b0, 24'h0, 6'b00_10_01, {TK0, TK2, TK1}, 15'd0, "ctrl_b", 1'b1);
    drive(1'b0, 24'h0, 6'b01_11_10, {TK1, TK3, TK2}, 15'd0, "ctrl_c", 1'b1);
    drive(1'b0, 24'h0, 6'b10_00_11, {TK2, TK0, TK3}, 15'd0, "ctrl_d", 1'b1);

    // ch0 zeros, ch1 FF/0E/F0, ch2 0F repeated.
    drive(1'b1, 24'h0FFF00, 6'd0, {10'b0100000101, 10'b1000000000, S00},
          {5'b11100, 5'b11000, 5'b11000}, "data_1", 1'b1);
    drive(1'b1, 24'h0F0E00, 6'd0, {10'b1111111010, 10'b0111111010, 10'b1111111111},
          {5'b00010, 5'b11100, 5'b00010}, "data_2", 1'b1);
    drive(1'b1, 24'h0FF000, 6'd0, {10'b0100000101, 10'b0011111010, S00},
          {5'b11110, 5'b11110, 5'b11010}, "data_3", 1'b1);

    // One-cycle blanking gap, then data restarts from tally 0.
    drive(1'b0, 24'h0, 6'b00_00_00, {TK0, TK0, TK0}, 15'd0, "blank_1", 1'b1);
    drive(1'b1, 24'h0FFF00, 6'd0, {10'b0100000101, 10'b1000000000, S00},
          {5'b11100, 5'b11000, 5'b11000}, "data_4", 1'b1);
    drive(1'b0, 24'h0, 6'b11_11_11, {TK3, TK3, TK3}, 15'd0, "blank_2", 1'b1);
    drive(1'b1, 24'h000EF0, 6'd0, {S00, 10'b0111111010, 10'b1000000101},
          {5'b11000, 5'b00100, 5'b11100}, "data_5", 1'b1);
    drive(1'b1, 24'h000EF0, 6'd0, {10'b1111111111, 10'b1100000101, 10'b0011111010},
          {5'b00010, 5'b00010, 5'b11110}, "data_6", 1'b1);

    // Reset in the middle of a zeros run; first symbol after release starts from 0.
    drive(1'b0, 24'h0, 6'd0, {TK0, TK0, TK0}, 15'd0, "blank_3", 1'b1);
    drive(1'b1, 24'h0, 6'd0, {S00, S00, S00}, {5'b11000, 5'b11000, 5'b11000}, "data_7", 1'b1);
    drive(1'b1, 24'h0, 6'd0, {3{10'b1111111111}}, {3{5'b00010}}, "data_killed", 1'b1);
    reset_cycle("reset_mid");
    drive(1'b1, 24'h0, 6'd0, {S00, S00, S00}, {5'b11000, 5'b11000, 5'b11000}, "data_8", 1'b1);

    reset_cycle("reset_soak");
    soak(3000);

    for (int i = 0; i < 8 && sb.size() > 0; i++) begin
      @(posedge clk_in); #1;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain pending=%0d required=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
